// File: rtl/stack_ctrl_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | stack_ctrl_pkg                                                    |
// | Shared data width and stack operation encodings.                  |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
`ifndef WIDTH
`define WIDTH 16
`endif

package stack_ctrl_pkg;

    localparam int c_WIDTH = `WIDTH;

    typedef enum logic [1:0] {
        OP_NOP     = 2'b00,
        OP_PUSH    = 2'b01,
        OP_POP     = 2'b10,
        OP_REPLACE = 2'b11
    } op_e;

endpackage
`default_nettype wire

// File: rtl/stack_ctrl_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | stack_ctrl_if                                                     |
// | Operation request and stack status bundle for stack_ctrl.         |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
interface stack_ctrl_if #(
    parameter int DEPTH = 4
);
    import stack_ctrl_pkg::*;

    logic               op_valid;
    logic               op_ready;
    op_e                op;
    logic [c_WIDTH-1:0] op_data;
    logic               flush;
    logic               clr_err;
    logic [c_WIDTH-1:0] tos;
    logic [c_WIDTH-1:0] nos;
    logic [DEPTH:0]     count;
    logic               empty;
    logic               full;
    logic               overflow;
    logic               underflow;

    modport master (
        output op_valid, op, op_data, flush, clr_err,
        input  op_ready, tos, nos, count, empty, full, overflow, underflow
    );

    modport slave (
        input  op_valid, op, op_data, flush, clr_err,
        output op_ready, tos, nos, count, empty, full, overflow, underflow
    );

endinterface
`default_nettype wire

// File: rtl/stack_ctrl_stack.sv
`default_nettype none
// +------------------------------------------------------------------+
// | stack_ctrl_stack                                                  |
// | Entry storage below TOS: one sync write port, async read port.    |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module stack_ctrl_stack
    import stack_ctrl_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  wire logic               clk,
    input  wire logic               i_we,
    input  wire logic [DEPTH-1:0]   i_waddr,
    input  wire logic [c_WIDTH-1:0] i_wdata,
    input  wire logic [DEPTH-1:0]   i_raddr,
    output logic      [c_WIDTH-1:0] o_rdata
);

    logic [c_WIDTH-1:0] r_mem [2**DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule
`default_nettype wire

// File: rtl/stack_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | stack_ctrl                                                        |
// | Registered-TOS stack with memory scrub on reset and flush.        |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module stack_ctrl
    import stack_ctrl_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input wire logic   clk,
    input wire logic   reset,
    stack_ctrl_if.slave bus
);

    localparam logic [0:0]       c_S_INIT   = 1'b0;
    localparam logic [0:0]       c_S_RUN    = 1'b1;
    localparam logic [DEPTH:0]   c_CNT_FULL = (DEPTH+1)'(2**DEPTH + 1);
    localparam logic [DEPTH:0]   c_CNT_ONE  = (DEPTH+1)'(1);
    localparam logic [DEPTH:0]   c_CNT_TWO  = (DEPTH+1)'(2);
    localparam logic [DEPTH-1:0] c_PTR_ONE  = DEPTH'(1);

    logic [0:0]         r_state,  w_state_nxt;
    logic [DEPTH-1:0]   r_scrub,  w_scrub_nxt;
    logic [DEPTH-1:0]   r_sp,     w_sp_nxt;
    logic [DEPTH:0]     r_count,  w_count_nxt;
    logic [c_WIDTH-1:0] r_tos,    w_tos_nxt;
    logic               r_ovf,    w_ovf_nxt;
    logic               r_unf,    w_unf_nxt;

    logic               w_accept;
    logic               w_ovf_ev;
    logic               w_unf_ev;
    logic               w_mem_we;
    logic [DEPTH-1:0]   w_mem_waddr;
    logic [c_WIDTH-1:0] w_mem_wdata;
    logic [c_WIDTH-1:0] w_mem_rdata;

    assign bus.op_ready = (r_state == c_S_RUN) && !bus.flush;
    assign w_accept     = bus.op_valid && bus.op_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_S_INIT;
            r_scrub <= '0;
            r_sp    <= '1;
            r_count <= '0;
            r_tos   <= '0;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_scrub <= w_scrub_nxt;
            r_sp    <= w_sp_nxt;
            r_count <= w_count_nxt;
            r_tos   <= w_tos_nxt;
            r_ovf   <= w_ovf_nxt;
            r_unf   <= w_unf_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_scrub_nxt = r_scrub;
        w_sp_nxt    = r_sp;
        w_count_nxt = r_count;
        w_tos_nxt   = r_tos;
        w_ovf_ev    = 1'b0;
        w_unf_ev    = 1'b0;
        w_mem_we    = 1'b0;
        w_mem_waddr = r_sp;
        w_mem_wdata = '0;

        if (r_state == c_S_INIT) begin
            // Scrub owns the write port for the whole INIT phase.
            w_mem_we    = 1'b1;
            w_mem_waddr = r_scrub;
            if (bus.flush) begin
                w_scrub_nxt = '0;
            end else if (r_scrub == '1) begin
                w_scrub_nxt = '0;
                w_state_nxt = c_S_RUN;
            end else begin
                w_scrub_nxt = r_scrub + c_PTR_ONE;
            end
        end else if (bus.flush) begin
            w_state_nxt = c_S_INIT;
            w_scrub_nxt = '0;
            w_sp_nxt    = '1;
            w_count_nxt = '0;
            w_tos_nxt   = '0;
        end else if (w_accept) begin
            case (bus.op)
                OP_PUSH: begin
                    if (r_count == c_CNT_FULL) begin
                        w_ovf_ev = 1'b1;
                    end else begin
                        // Old TOS spills to memory only if it held a live value.
                        if (r_count != '0) begin
                            w_mem_we    = 1'b1;
                            w_mem_waddr = r_sp + c_PTR_ONE;
                            w_mem_wdata = r_tos;
                            w_sp_nxt    = r_sp + c_PTR_ONE;
                        end
                        w_tos_nxt   = bus.op_data;
                        w_count_nxt = r_count + c_CNT_ONE;
                    end
                end
                OP_POP: begin
                    if (r_count == '0) begin
                        w_unf_ev = 1'b1;
                    end else if (r_count == c_CNT_ONE) begin
                        w_tos_nxt   = '0;
                        w_count_nxt = '0;
                    end else begin
                        w_tos_nxt   = w_mem_rdata;
                        w_mem_we    = 1'b1;
                        w_mem_waddr = r_sp;
                        w_sp_nxt    = r_sp - c_PTR_ONE;
                        w_count_nxt = r_count - c_CNT_ONE;
                    end
                end
                OP_REPLACE: begin
                    w_tos_nxt = bus.op_data;
                    if (r_count == '0) begin
                        w_count_nxt = c_CNT_ONE;
                    end
                end
                default: ;
            endcase
        end

        // A fresh error event wins over a same-cycle clear.
        w_ovf_nxt = (r_ovf && !bus.clr_err) || w_ovf_ev;
        w_unf_nxt = (r_unf && !bus.clr_err) || w_unf_ev;
    end

    stack_ctrl_stack #(
        .DEPTH (DEPTH)
    ) u_stack (
        .clk     (clk),
        .i_we    (w_mem_we),
        .i_waddr (w_mem_waddr),
        .i_wdata (w_mem_wdata),
        .i_raddr (r_sp),
        .o_rdata (w_mem_rdata)
    );

    assign bus.tos       = r_tos;
    assign bus.nos       = (r_count >= c_CNT_TWO) ? w_mem_rdata : '0;
    assign bus.count     = r_count;
    assign bus.empty     = (r_count == '0);
    assign bus.full      = (r_count == c_CNT_FULL);
    assign bus.overflow  = r_ovf;
    assign bus.underflow = r_unf;

endmodule
`default_nettype wire

// File: tb/tb_stack_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_stack_ctrl                                                     |
// | Directed + random stimulus against a queue-based stack model.     |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module tb_stack_ctrl;
    import stack_ctrl_pkg::*;

    localparam int DEPTH = 4;
    localparam int CAP   = 2**DEPTH + 1;
    localparam int SCRUB = 2**DEPTH;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    stack_ctrl_if #(.DEPTH(DEPTH)) bus ();

    stack_ctrl #(.DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int q[$];
    int scrub_left = SCRUB;
    bit m_ovf = 1'b0;
    bit m_unf = 1'b0;
    int n_cmp = 0;
    int n_bad = 0;
    bit watch_aaaa = 1'b0;
    bit saw_aaaa = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge(input bit v, input logic [1:0] o, input logic [15:0] d,
                              input bit fl, input bit ce, input bit rs);
        bit ovf_ev = 1'b0;
        bit unf_ev = 1'b0;
        if (rs) begin
            q.delete();
            scrub_left = SCRUB;
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else begin
            if (scrub_left > 0) begin
                scrub_left = fl ? SCRUB : scrub_left - 1;
            end else if (fl) begin
                q.delete();
                scrub_left = SCRUB;
            end else if (v) begin
                case (o)
                    2'b01: if (q.size() == CAP) ovf_ev = 1'b1; else q.push_back(int'(d));
                    2'b10: if (q.size() == 0) unf_ev = 1'b1; else void'(q.pop_back());
                    2'b11: if (q.size() == 0) q.push_back(int'(d)); else q[q.size()-1] = int'(d);
                    default: ;
                endcase
            end
            m_ovf = (m_ovf && !ce) || ovf_ev;
            m_unf = (m_unf && !ce) || unf_ev;
        end
    endtask

    task automatic check_all(input bit fl);
        int sz = q.size();
        int e_tos = (sz > 0) ? q[sz-1] : 0;
        int e_nos = (sz > 1) ? q[sz-2] : 0;
        chk("op_ready",  32'(bus.op_ready),  32'(scrub_left == 0 && !fl));
        chk("tos",       32'(bus.tos),       e_tos);
        chk("nos",       32'(bus.nos),       e_nos);
        chk("count",     32'(bus.count),     sz);
        chk("empty",     32'(bus.empty),     32'(sz == 0));
        chk("full",      32'(bus.full),      32'(sz == CAP));
        chk("overflow",  32'(bus.overflow),  32'(m_ovf));
        chk("underflow", 32'(bus.underflow), 32'(m_unf));
        if (watch_aaaa && bus.tos == 16'hAAAA) saw_aaaa = 1'b1;
    endtask

    task automatic step(input bit v, input logic [1:0] o, input logic [15:0] d,
                        input bit fl, input bit ce, input bit rs);
        bus.op_valid = v;
        bus.op       = op_e'(o);
        bus.op_data  = d;
        bus.flush    = fl;
        bus.clr_err  = ce;
        reset        = rs;
        @(posedge clk);
        model_edge(v, o, d, fl, ce, rs);
        #1;
        check_all(fl);
    endtask

    task automatic idle();
        step(1'b0, 2'b00, 16'h0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic push(input logic [15:0] d);
        step(1'b1, 2'b01, d, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic pop();
        step(1'b1, 2'b10, 16'h0, 1'b0, 1'b0, 1'b0);
    endtask

    // Counts cycles with op_ready low, starting from the current sample.
    task automatic wait_scrub(input string tag);
        int n = 0;
        while (!bus.op_ready && n < 100) begin
            n++;
            idle();
        end
        chk(tag, n, SCRUB);
    endtask

    initial begin
        bus.op_valid = 1'b0;
        bus.op       = OP_NOP;
        bus.op_data  = '0;
        bus.flush    = 1'b0;
        bus.clr_err  = 1'b0;

        step(1'b0, 2'b00, 16'h0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 2'b00, 16'h0, 1'b0, 1'b0, 1'b1);
        wait_scrub("scrub_after_reset");

        push(16'h1111); push(16'h2222); push(16'h3333);
        chk("p3_tos", 32'(bus.tos), 32'h3333);
        chk("p3_nos", 32'(bus.nos), 32'h2222);
        chk("p3_cnt", 32'(bus.count), 3);
        pop(); pop();
        chk("pp_tos", 32'(bus.tos), 32'h1111);
        chk("pp_nos", 32'(bus.nos), 0);
        chk("pp_cnt", 32'(bus.count), 1);
        pop();

        for (int i = 1; i <= 17; i++) push(16'(i));
        chk("full_flag", 32'(bus.full), 1);
        chk("full_tos", 32'(bus.tos), 17);
        push(16'd18);
        chk("ovf_flag", 32'(bus.overflow), 1);
        chk("ovf_tos", 32'(bus.tos), 17);
        chk("ovf_cnt", 32'(bus.count), 17);
        for (int k = 16; k >= 1; k--) begin
            pop();
            chk("pop_seq", 32'(bus.tos), k);
        end
        pop();
        step(1'b0, 2'b00, 16'h0, 1'b0, 1'b1, 1'b0);

        pop();
        chk("unf_flag", 32'(bus.underflow), 1);
        chk("unf_cnt", 32'(bus.count), 0);
        step(1'b1, 2'b10, 16'h0, 1'b0, 1'b1, 1'b0);
        chk("unf_sticky", 32'(bus.underflow), 1);
        step(1'b0, 2'b00, 16'h0, 1'b0, 1'b1, 1'b0);
        chk("unf_cleared", 32'(bus.underflow), 0);

        push(16'h0001); push(16'h0002); push(16'h0003);
        watch_aaaa = 1'b1;
        step(1'b1, 2'b01, 16'hAAAA, 1'b1, 1'b0, 1'b0);
        chk("flush_cnt", 32'(bus.count), 0);
        chk("flush_tos", 32'(bus.tos), 0);
        wait_scrub("scrub_after_flush");
        for (int i = 0; i < 4; i++) idle();
        watch_aaaa = 1'b0;
        chk("aaaa_never_on_tos", 32'(saw_aaaa), 0);

        step(1'b0, 2'b00, 16'h0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) idle();
        step(1'b1, 2'b01, 16'h5555, 1'b1, 1'b1, 1'b1);
        chk("rst_mid_scrub_ready", 32'(bus.op_ready), 0);
        wait_scrub("scrub_after_rst_scrub");
        for (int i = 0; i < 5; i++) push(16'(16'h100 + i));
        chk("pre_rst_cnt", 32'(bus.count), 5);
        step(1'b1, 2'b10, 16'h0, 1'b0, 1'b0, 1'b1);
        chk("rst_mid_stack_cnt", 32'(bus.count), 0);
        chk("rst_mid_stack_tos", 32'(bus.tos), 0);
        wait_scrub("scrub_after_rst_stack");

        for (int ph = 0; ph < 3; ph++) begin
            for (int c = 0; c < 700; c++) begin
                int r = int'($urandom_range(0, 99));
                logic [1:0] o;
                if (ph == 0)      o = (r < 70) ? 2'b01 : 2'($urandom_range(0, 3));
                else if (ph == 1) o = (r < 70) ? 2'b10 : 2'($urandom_range(0, 3));
                else              o = 2'($urandom_range(0, 3));
                step(1'($urandom_range(0, 9) < 8), o, 16'($urandom),
                     1'($urandom_range(0, 99) < 2), 1'($urandom_range(0, 19) == 0),
                     1'($urandom_range(0, 299) == 0));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/stack_ctrl.md
STACK_CTRL -- requirements
Module: stack_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning log2 of the number of memory entries below TOS.
REQ-002 SHALL take its data width from the shared `WIDTH define (16), not from a parameter.
REQ-003 clk  in  1  sole clock; all state updates on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-005 op_valid  in  1  operation request.
REQ-006 op_ready  out  1  block can accept an operation this cycle.
REQ-007 op  in  2  00 NOP, 01 PUSH, 10 POP, 11 REPLACE.
REQ-008 op_data  in  WIDTH  value for PUSH and REPLACE.
REQ-009 flush  in  1  discard stack contents and re-scrub memory.
REQ-010 clr_err  in  1  clear the sticky error flags.
REQ-011 tos  out  WIDTH  top of stack, registered.
REQ-012 nos  out  WIDTH  next of stack, combinational from memory.
REQ-013 count  out  DEPTH+1  live entries, 0..2**DEPTH+1.
REQ-014 empty, full  out  1 each  count==0 and count==2**DEPTH+1.
REQ-015 overflow, underflow  out  1 each  sticky error flags.

Function
REQ-016 SHALL implement an FSM with states INIT (memory scrub) and RUN.
REQ-017 In INIT: write 0 to memory addresses 0..2**DEPTH-1, one per cycle, ascending; then move to RUN; op_ready=0 throughout.
REQ-018 op_ready SHALL equal (state==RUN) && !flush; an op is accepted when op_valid && op_ready.
REQ-019 Storage: TOS in register tos; entries below TOS in memory; stack pointer sp (DEPTH bits) addresses the NOS entry.
REQ-020 Accepted PUSH, count<full: memory[sp+1] <= tos when count>=1; tos <= op_data; sp advances only when count>=1; count+1.
REQ-021 Accepted POP, count>=2: tos <= memory[sp]; memory[sp] <= 0; sp-1; count-1.
REQ-022 Accepted POP, count==1: tos <= 0; count <= 0; sp unchanged.
REQ-023 Accepted REPLACE: tos <= op_data; count, sp, memory unchanged; on empty stack count becomes 1.
REQ-024 NOP or no accepted op: no state change.
REQ-025 PUSH when full: rejected (no state change); overflow <= 1.
REQ-026 POP when empty: rejected (no state change); underflow <= 1.
REQ-027 sp arithmetic SHALL be modulo 2**DEPTH; count never wraps.
REQ-028 nos SHALL be memory[sp] when count>=2, else 0.
REQ-029 tos SHALL read 0 whenever count==0.
REQ-030 All updates SHALL be visible the cycle after acceptance (latency 1).
REQ-031 flush in RUN: next cycle count=0, tos=0, sp=all-ones, state=INIT; a concurrent op is not accepted.
REQ-032 flush during INIT: restart the scrub at address 0.
REQ-033 clr_err clears both flags next cycle; a same-cycle new error event takes priority (flag stays 1).

Reset
REQ-034 On reset: state=INIT, scrub address=0, sp=all-ones, count=0, tos=0, overflow=0, underflow=0, op_ready=0.
REQ-035 Reset SHALL take priority over flush, clr_err and any op; reset mid-scrub restarts the scrub.

Structure
REQ-036 WIDTH and the op encodings (NOP/PUSH/POP/REPLACE) SHALL live in the shared common header; FSM state encoding stays local.
REQ-037 SHALL instantiate exactly one sub-module, stack, with DEPTH passed through; the write port is muxed between the scrub and the op path, and the read address is sp.

Verification
REQ-038 Reset, hold idle: op_ready=0 for exactly 16 cycles (DEPTH=4), then 1; count=0, tos=0, nos=0.
REQ-039 PUSH 0x1111, 0x2222, 0x3333 -> tos=0x3333, nos=0x2222, count=3; POP twice -> tos=0x1111, nos=0, count=1.
REQ-040 17 PUSHes 1..17 -> full=1, tos=17; 18th PUSH -> overflow=1, tos=17, count=17; pops return 16..1 in order.
REQ-041 POP on empty -> underflow=1, count=0; clr_err with a simultaneous POP on empty -> underflow remains 1.
REQ-042 3 PUSHes, then flush with a concurrent PUSH 0xAAAA -> next cycle count=0, tos=0, op_ready=0 for 16 cycles; 0xAAAA never appears on tos.
REQ-043 Reset asserted mid-scrub and mid-stack (count=5) -> all outputs at reset values next cycle; full 16-cycle scrub repeated.
